// File: rtl/tb_pkg.sv
// tb_pkg: shared types and helpers for the trackball reader.
//   CNT_W     - default per-axis counter width (fills data_out[3:0]).
//   axis_e    - axis select (AXIS_H / AXIS_V), driven from addr[0].
//   tb_axis_t - readout record for one axis: direction latch + counter.
//   gray_step - quadrature decode, used when TB_QUAD_EN is defined.
package tb_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic {AXIS_H = 1'b0, AXIS_V = 1'b1} axis_e;

  typedef struct packed {
    logic             dir;
    logic [CNT_W-1:0] cnt;
  } tb_axis_t;

  // Gray-to-binary turns 00,01,11,10 into 0,1,2,3; the mod-4 difference is
  // then 1 for a forward step, 3 for a reverse step, 2 for an illegal jump.
  function automatic logic signed [1:0] gray_step(input logic [1:0] prev,
                                                  input logic [1:0] cur);
    logic [1:0] ip;
    logic [1:0] ic;
    logic [1:0] d;
    ip = {prev[1], prev[1] ^ prev[0]};
    ic = {cur[1], cur[1] ^ cur[0]};
    d  = ic - ip;
    case (d)
      2'd1:    return 2'sb01;
      2'd3:    return 2'sb11;
      default: return 2'sb00;
    endcase
  endfunction

endpackage

// File: rtl/tb_axis.sv
// tb_axis: one trackball axis - synchronizer, stability filter, edge detect
// and wrapping position counter.
//   CLOCK_50, resetSystem (async, active low)
//   clk_i, dir_i : raw asynchronous trackball lines
//   clr_i        : one-cycle counter clear (already synchronous)
//   cnt_o, dir_o : counter and direction latch
// With TB_QUAD_EN defined, clk_i/dir_i are decoded as a quadrature A/B pair.
module tb_axis
  import tb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 32,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             CLOCK_50,
  input  logic             resetSystem,
  input  logic             clk_i,
  input  logic             dir_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             dir_o
);

  localparam int unsigned FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sclk_q, sdir_q;
  logic [1:0]             sync_w;
  logic [1:0]             filt_q, filt_d;   // [1] = clk/A, [0] = dir/B
  logic [FW-1:0]          fcnt_q [2];
  logic [FW-1:0]          fcnt_d [2];
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dirl_q, dirl_d;
`ifdef TB_QUAD_EN
  logic [1:0]             prev_q;
  logic signed [1:0]      step_w;
`else
  logic                   prev_q;
  logic                   rise_w;
`endif

  assign sync_w = {sclk_q[SYNC_STAGES-1], sdir_q[SYNC_STAGES-1]};

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = '0;
      // Count consecutive cycles the synced level disagrees; any agreement
      // restarts the run, so short pulses never flip the filtered level.
      if (sync_w[i] != filt_q[i]) begin
        if (fcnt_q[i] == FW'(FILT_CYCLES - 1))
          filt_d[i] = sync_w[i];
        else
          fcnt_d[i] = fcnt_q[i] + FW'(1);
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    dirl_d = dirl_q;
`ifdef TB_QUAD_EN
    step_w = gray_step(prev_q, filt_q);
    if (clr_i) begin
      cnt_d = '0;
    end else if (step_w == 2'sb01) begin
      cnt_d  = cnt_q + CNT_W'(1);
      dirl_d = 1'b1;
    end else if (step_w == 2'sb11) begin
      cnt_d  = cnt_q - CNT_W'(1);
      dirl_d = 1'b0;
    end
`else
    rise_w = filt_q[1] & ~prev_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (rise_w) begin
      dirl_d = filt_q[0];
      cnt_d  = filt_q[0] ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
    end
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge resetSystem) begin
    if (!resetSystem) begin
      sclk_q <= '0;
      sdir_q <= '0;
      filt_q <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
      dirl_q <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], clk_i};
      sdir_q <= {sdir_q[SYNC_STAGES-2:0], dir_i};
      filt_q <= filt_d;
`ifdef TB_QUAD_EN
      prev_q <= filt_q;
`else
      prev_q <= filt_q[1];
`endif
      cnt_q  <= cnt_d;
      dirl_q <= dirl_d;
      for (int unsigned i = 0; i < 2; i++) fcnt_q[i] <= fcnt_d[i];
    end
  end

  assign cnt_o = cnt_q;
  assign dir_o = dirl_q;

endmodule

// File: rtl/trackball_reader.sv
// trackball_reader: trackball input stage for the CPU data bus.
//   CLOCK_50, resetSystem (async, active low)
//   horclk1/hordir1/verclk1/verdir1, horclk2/... : raw trackball lines
//   steerclr_l : active-low clear strobe (1.5 MHz domain), falling edge clears
//   ballselect (player), seltri (axis), rd_l (active-low read)
//   data_out   : {dir, 3'b000, cnt} of the selected axis, registered
//   data_oe    : registered ~rd_l
// Build option: define TB_QUAD_EN for quadrature (4x) decoding per axis.
module trackball_reader
  import tb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 32,
  parameter int unsigned CNT_W       = tb_pkg::CNT_W
) (
  input  logic       CLOCK_50,
  input  logic       resetSystem,
  input  logic       horclk1,
  input  logic       hordir1,
  input  logic       verclk1,
  input  logic       verdir1,
  input  logic       horclk2,
  input  logic       hordir2,
  input  logic       verclk2,
  input  logic       verdir2,
  input  logic       steerclr_l,
  input  logic       ballselect,
  input  logic       seltri,
  input  logic       rd_l,
  output logic [7:0] data_out,
  output logic       data_oe
);

  typedef logic [tb_pkg::CNT_W-1:0] pkg_cnt_t;

  logic [SYNC_STAGES-1:0] sclr_q;
  logic                   sclr_prev_q;
  logic                   clr_w;
  logic [3:0]             clk_w, dir_w, dirl_w;
  logic [CNT_W-1:0]       cnt_w [4];
  tb_axis_t               axis_w [4];
  axis_e                  axis_sel;
  tb_axis_t               sel_w;
  logic [7:0]             data_d;
  logic [7:0]             data_q;
  logic                   oe_q;

  // Axis index = {ballselect, seltri}: P1H, P1V, P2H, P2V.
  assign clk_w = {verclk2, horclk2, verclk1, horclk1};
  assign dir_w = {verdir2, hordir2, verdir1, hordir1};

  assign clr_w = sclr_prev_q & ~sclr_q[SYNC_STAGES-1];

  for (genvar g = 0; g < 4; g++) begin : g_axis
    tb_axis #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CYCLES(FILT_CYCLES),
      .CNT_W      (CNT_W)
    ) u_axis (
      .CLOCK_50   (CLOCK_50),
      .resetSystem(resetSystem),
      .clk_i      (clk_w[g]),
      .dir_i      (dir_w[g]),
      .clr_i      (clr_w),
      .cnt_o      (cnt_w[g]),
      .dir_o      (dirl_w[g])
    );
    assign axis_w[g] = '{dir: dirl_w[g], cnt: pkg_cnt_t'(cnt_w[g])};
  end

  always_comb begin
    axis_sel = axis_e'(seltri);
    sel_w    = axis_w[{ballselect, axis_sel}];
    data_d   = {sel_w.dir, 3'b000, sel_w.cnt};
  end

  always_ff @(posedge CLOCK_50 or negedge resetSystem) begin
    if (!resetSystem) begin
      sclr_q      <= '0;
      sclr_prev_q <= 1'b0;
      data_q      <= '0;
      oe_q        <= 1'b0;
    end else begin
      sclr_q      <= {sclr_q[SYNC_STAGES-2:0], steerclr_l};
      sclr_prev_q <= sclr_q[SYNC_STAGES-1];
      data_q      <= data_d;
      oe_q        <= ~rd_l;
    end
  end

  assign data_out = data_q;
  assign data_oe  = oe_q;

endmodule

// File: tb/tb_trackball_reader.sv
module tb_trackball_reader;

  localparam int FILT = 32;

  logic       CLOCK_50 = 1'b0;
  logic       resetSystem;
  logic [3:0] tclk, tdir;   // index {player, axis}: P1H, P1V, P2H, P2V
  logic       steerclr_l, ballselect, seltri, rd_l;
  logic [7:0] data_out;
  logic       data_oe;

  always #10 CLOCK_50 = ~CLOCK_50;

  trackball_reader #(
    .SYNC_STAGES(2),
    .FILT_CYCLES(FILT),
    .CNT_W      (4)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .resetSystem(resetSystem),
    .horclk1    (tclk[0]),
    .hordir1    (tdir[0]),
    .verclk1    (tclk[1]),
    .verdir1    (tdir[1]),
    .horclk2    (tclk[2]),
    .hordir2    (tdir[2]),
    .verclk2    (tclk[3]),
    .verdir2    (tdir[3]),
    .steerclr_l (steerclr_l),
    .ballselect (ballselect),
    .seltri     (seltri),
    .rd_l       (rd_l),
    .data_out   (data_out),
    .data_oe    (data_oe)
  );

  int   checks = 0;
  int   fails  = 0;
  int   exp_cnt [4];
  bit   exp_dir [4];
  bit   settled = 1'b0;
  logic rd_at_edge = 1'b1;

  function automatic logic [7:0] model_byte(input int a);
    logic [3:0] c;
    c = 4'(exp_cnt[a]);
    return {exp_dir[a], 3'b000, c};
  endfunction

  function automatic int wrap16(input int v);
    return ((v % 16) + 16) % 16;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLOCK_50) rd_at_edge <= rd_l;

  // Continuous comparison against the model whenever nothing is in flight.
  always @(negedge CLOCK_50) begin
    if (settled) begin
      check("model_data", data_out, model_byte(int'({ballselect, seltri})));
      check("model_oe", {7'b0, data_oe}, {7'b0, ~rd_at_edge});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic settle();
    cyc(60);
    settled = 1'b1;
  endtask

  task automatic model_clear_all();
    for (int a = 0; a < 4; a++) exp_cnt[a] = 0;
  endtask

  task automatic lit(input string name, input int a, input logic [7:0] v);
    logic [1:0] s;
    settled = 1'b0;
    s = 2'(a);
    {ballselect, seltri} = s;
    cyc(2);
    check(name, data_out, v);
    settled = 1'b1;
  endtask

  // Drive the clk lines in mask high for hi cycles then low for lo cycles.
  // Only a high phase of at least FILT cycles is a real edge.
  task automatic pulse(input logic [3:0] mask, input int hi, input int lo);
    settled = 1'b0;
    tclk = tclk | mask;
    cyc(hi);
    tclk = tclk & ~mask;
    cyc(lo);
    if (hi >= FILT) begin
      for (int a = 0; a < 4; a++) begin
        if (mask[a]) begin
          exp_cnt[a] = wrap16(exp_cnt[a] + (tdir[a] ? 1 : -1));
          exp_dir[a] = tdir[a];
        end
      end
    end
  endtask

`ifdef TB_QUAD_EN
  function automatic int gidx(input logic [1:0] v);
    case (v)
      2'b00: return 0;
      2'b01: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  task automatic qset(input logic [1:0] v);
    int d;
    settled = 1'b0;
    d = (gidx(v) - gidx({tclk[0], tdir[0]}) + 4) % 4;
    {tclk[0], tdir[0]} = v;
    cyc(60);
    if (d == 1) begin
      exp_cnt[0] = wrap16(exp_cnt[0] + 1);
      exp_dir[0] = 1'b1;
    end else if (d == 3) begin
      exp_cnt[0] = wrap16(exp_cnt[0] - 1);
      exp_dir[0] = 1'b0;
    end
    settled = 1'b1;
  endtask
`endif

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    resetSystem = 1'b0;
    tclk = '0; tdir = '0;
    steerclr_l = 1'b1; ballselect = 1'b0; seltri = 1'b0; rd_l = 1'b1;
    model_clear_all();
    for (int a = 0; a < 4; a++) exp_dir[a] = 1'b0;
    cyc(5);
    check("reset_data", data_out, 8'h00);
    check("reset_oe", {7'b0, data_oe}, 8'h00);
    resetSystem = 1'b1;
    cyc(5);
    rd_l = 1'b0;
    cyc(1);
    check("oe_after_rd", {7'b0, data_oe}, 8'h01);
    check("idle_data", data_out, 8'h00);
    settle();

`ifndef TB_QUAD_EN
    tdir[0] = 1'b1;
    cyc(60);
    repeat (5) pulse(4'b0001, 100, 100);
    settle();
    lit("p1h_5", 0, 8'h85);

    // Asynchronous reset in the middle of operation.
    settled = 1'b0;
    resetSystem = 1'b0;
    #1;
    check("async_reset_data", data_out, 8'h00);
    check("async_reset_oe", {7'b0, data_oe}, 8'h00);
    model_clear_all();
    for (int a = 0; a < 4; a++) exp_dir[a] = 1'b0;
    cyc(3);
    resetSystem = 1'b1;
    settle();

    repeat (3) pulse(4'b1000, 100, 100);
    settle();
    lit("p2v_3", 3, 8'h0D);
    lit("p1h_zero", 0, 8'h00);
    lit("p1v_zero", 1, 8'h00);

    repeat (17) pulse(4'b0001, 100, 100);
    settle();
    lit("p1h_wrap", 0, 8'h81);

    pulse(4'b0001, 20, 100);
    settle();
    lit("glitch_20", 0, 8'h81);
    pulse(4'b0001, 40, 100);
    settle();
    lit("pulse_40", 0, 8'h82);

    tdir[2] = 1'b1;
    cyc(60);
    pulse(4'b1111, 100, 100);
    settle();
    lit("simul_p1h", 0, 8'h83);
    lit("simul_p1v", 1, 8'h0F);
    lit("simul_p2h", 2, 8'h81);
    lit("simul_p2v", 3, 8'h0C);

    // Clear lands on the same cycle as the filtered horclk1 rise: both paths
    // share the synchronizer depth, the filter adds FILT cycles.
    settled = 1'b0;
    tclk[0] = 1'b1;
    cyc(FILT);
    steerclr_l = 1'b0;
    cyc(68);
    tclk[0] = 1'b0;
    cyc(100);
    model_clear_all();
    settle();
    lit("clr_p1h", 0, 8'h80);
    lit("clr_p1v", 1, 8'h00);
    lit("clr_p2h", 2, 8'h80);
    lit("clr_p2v", 3, 8'h00);

    // Still low: no further clears.
    repeat (3) pulse(4'b0001, 100, 100);
    settle();
    lit("held_clr", 0, 8'h83);
    cyc(200);
    steerclr_l = 1'b1;
    cyc(20);
    lit("clr_release", 0, 8'h83);
`else
    qset(2'b01); qset(2'b11); qset(2'b10); qset(2'b00);
    lit("quad_fwd", 0, 8'h84);
    qset(2'b10); qset(2'b11); qset(2'b01); qset(2'b00);
    lit("quad_rev", 0, 8'h00);
    qset(2'b11);
    lit("quad_jump", 0, 8'h00);
    qset(2'b00);
    lit("quad_jump_back", 0, 8'h00);
`endif

    settled = 1'b0;
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
